// File: rtl/beam_mux_n.sv
// Packet-granular AXI-Stream demultiplexer: one source to NUM_DAC DAC sinks,
// with a single registered output stage shared by all sinks.
//
// state  | meaning
// IDLE   | next accepted beat is a packet head; dac_sel is sampled on it
// IN_PKT | packet in progress; route held from the head beat
module beam_mux_n #(
   parameter int DWIDTH  = 32,
   parameter int NUM_DAC = 3,
   parameter int SEL_W   = $clog2(NUM_DAC + 1),
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SEL_W-1:0]           dac_sel,
   input  logic [DWIDTH-1:0]          axis_S_source_tdata,
   input  logic                       axis_S_source_tvalid,
   output logic                       axis_S_source_tready,
   input  logic                       axis_S_source_tlast,
   output logic [NUM_DAC*DWIDTH-1:0]  axis_M_dac_tdata,
   output logic [NUM_DAC-1:0]         axis_M_dac_tvalid,
   input  logic [NUM_DAC-1:0]         axis_M_dac_tready,
   output logic [NUM_DAC-1:0]         axis_M_dac_tlast,
   output logic [SEL_W-1:0]           cur_route,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam logic [SEL_W-1:0] DROP_RT = SEL_W'(NUM_DAC);
   localparam logic [SEL_W-1:0] LAST_RT = SEL_W'(NUM_DAC - 1);

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    route_q, route_d;
   logic                rr_mode_q, rr_mode_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                out_v_q, out_v_d;
   logic [DWIDTH-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic [SEL_W-1:0]    out_tgt_q, out_tgt_d;
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

   logic                sink_rdy;
   logic                s_ready;
   logic                accept;
   logic [SEL_W-1:0]    sel_route;
   logic [SEL_W-1:0]    route_now;
   logic                rr_now;

   always_comb begin
      sink_rdy = 1'b0;
      for (int k = 0; k < NUM_DAC; k++) begin
         if (out_tgt_q == SEL_W'(k)) sink_rdy = axis_M_dac_tready[k];
      end
   end

   assign s_ready = !rst && (!out_v_q || sink_rdy);
   assign accept  = axis_S_source_tvalid && s_ready;

   always_comb begin
      sel_route = DROP_RT;
      if (dac_sel == '0)          sel_route = rr_ptr_q;
      else if (dac_sel <= DROP_RT) sel_route = dac_sel - SEL_W'(1);
   end

   // Head beats route from the live select; body beats use the latched route.
   assign route_now = (state_q == IDLE) ? sel_route : route_q;
   assign rr_now    = (state_q == IDLE) ? (dac_sel == '0) : rr_mode_q;

   always_comb begin
      state_d    = state_q;
      route_d    = route_q;
      rr_mode_d  = rr_mode_q;
      rr_ptr_d   = rr_ptr_q;
      out_v_d    = out_v_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      out_tgt_d  = out_tgt_q;
      drop_cnt_d = drop_cnt_q;

      if (accept) begin
         state_d = axis_S_source_tlast ? IDLE : IN_PKT;
         if (state_q == IDLE) begin
            route_d   = sel_route;
            rr_mode_d = (dac_sel == '0);
         end
         if (axis_S_source_tlast && rr_now)
            rr_ptr_d = (rr_ptr_q == LAST_RT) ? '0 : rr_ptr_q + SEL_W'(1);
         if (axis_S_source_tlast && (route_now == DROP_RT) && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end

      if (accept && (route_now != DROP_RT)) begin
         out_v_d    = 1'b1;
         out_data_d = axis_S_source_tdata;
         out_last_d = axis_S_source_tlast;
         out_tgt_d  = route_now;
      end else if (out_v_q && sink_rdy) begin
         out_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         route_q    <= '0;
         rr_mode_q  <= 1'b0;
         rr_ptr_q   <= '0;
         out_v_q    <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         out_tgt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         route_q    <= route_d;
         rr_mode_q  <= rr_mode_d;
         rr_ptr_q   <= rr_ptr_d;
         out_v_q    <= out_v_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         out_tgt_q  <= out_tgt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      axis_M_dac_tvalid = '0;
      axis_M_dac_tlast  = '0;
      axis_M_dac_tdata  = '0;
      for (int k = 0; k < NUM_DAC; k++) begin
         axis_M_dac_tvalid[k]              = out_v_q && (out_tgt_q == SEL_W'(k));
         axis_M_dac_tlast[k]               = out_v_q && out_last_q && (out_tgt_q == SEL_W'(k));
         axis_M_dac_tdata[k*DWIDTH +: DWIDTH] = out_data_q;
      end
   end

   assign axis_S_source_tready = s_ready;
   assign cur_route            = route_q;
   assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_beam_mux_n.sv
// Directed bench for beam_mux_n: a 3-sink instance under test plus a 4-sink,
// 2-bit-counter instance fed the same source to see the wrap and saturation.
module tb_beam_mux_n;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    dac_sel;
   logic [31:0]   s_tdata;
   logic          s_tvalid;
   logic          s_tlast;
   logic [2:0]    m_tready;

   logic          s_tready;
   logic [95:0]   m_tdata;
   logic [2:0]    m_tvalid;
   logic [2:0]    m_tlast;
   logic [2:0]    cur_route;
   logic [15:0]   drop_cnt;

   logic          s_tready4;
   logic [127:0]  m_tdata4;
   logic [3:0]    m_tvalid4;
   logic [3:0]    m_tlast4;
   logic [2:0]    cur_route4;
   logic [1:0]    drop_cnt4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   beam_mux_n #(.DWIDTH(32), .NUM_DAC(3), .SEL_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .dac_sel(dac_sel),
      .axis_S_source_tdata(s_tdata), .axis_S_source_tvalid(s_tvalid),
      .axis_S_source_tready(s_tready), .axis_S_source_tlast(s_tlast),
      .axis_M_dac_tdata(m_tdata), .axis_M_dac_tvalid(m_tvalid),
      .axis_M_dac_tready(m_tready), .axis_M_dac_tlast(m_tlast),
      .cur_route(cur_route), .drop_cnt(drop_cnt)
   );

   beam_mux_n #(.DWIDTH(32), .NUM_DAC(4), .CNT_W(2)) dut4 (
      .clk(clk), .rst(rst), .dac_sel(dac_sel),
      .axis_S_source_tdata(s_tdata), .axis_S_source_tvalid(s_tvalid),
      .axis_S_source_tready(s_tready4), .axis_S_source_tlast(s_tlast),
      .axis_M_dac_tdata(m_tdata4), .axis_M_dac_tvalid(m_tvalid4),
      .axis_M_dac_tready(4'hF), .axis_M_dac_tlast(m_tlast4),
      .cur_route(cur_route4), .drop_cnt(drop_cnt4)
   );

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] d;
      logic        l;
      int          esink;   // 3 = dropped
      int          esink4;  // -1 = not checked on the 4-sink instance
   } beat_t;

   beat_t tbl[$];

   function automatic void add(input logic [2:0] sel, input logic [31:0] d,
                               input logic l, input int es, input int es4);
      beat_t b;
      b.sel = sel; b.d = d; b.l = l; b.esink = es; b.esink4 = es4;
      tbl.push_back(b);
   endfunction

   function automatic logic [2:0] oh3(input int s);
      logic [2:0] r;
      r = '0;
      if (s >= 0 && s < 3) r[s] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] oh4(input int s);
      logic [3:0] r;
      r = '0;
      if (s >= 0 && s < 4) r[s] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, then check outputs before the rising edge.
   task automatic cyc(input logic r, input logic [2:0] sel, input logic v,
                      input logic [31:0] d, input logic l, input logic [2:0] mrdy,
                      input logic e_srdy, input logic [2:0] e_mv,
                      input logic [2:0] e_ml, input logic [31:0] e_md);
      @(negedge clk);
      rst = r; dac_sel = sel; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mrdy;
      #1;
      chk("src_tready", 128'(s_tready), 128'(e_srdy));
      chk("dac_tvalid", 128'(m_tvalid), 128'(e_mv));
      chk("dac_tlast",  128'(m_tlast),  128'(e_ml));
      if (e_mv != 3'b000) chk("dac_tdata", 128'(m_tdata), 128'({3{e_md}}));
   endtask

   // Stream table beats back to back with all sinks ready, then two idle cycles.
   task automatic run_range(input int lo, input int hi);
      logic        pv;
      int          ps, ps4;
      logic [31:0] pd;
      logic        pl;
      pv = 1'b0; ps = 0; ps4 = -1; pd = '0; pl = 1'b0;
      for (int i = lo; i <= hi + 2; i++) begin
         logic [2:0] emv, eml;
         emv = pv ? oh3(ps) : 3'b000;
         eml = (pv && pl) ? oh3(ps) : 3'b000;
         if (i <= hi)
            cyc(1'b0, tbl[i].sel, 1'b1, tbl[i].d, tbl[i].l, 3'b111, 1'b1, emv, eml, pd);
         else
            cyc(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 3'b111, 1'b1, emv, eml, pd);
         if (pv && ps4 >= 0) begin
            chk("dac4_tvalid", 128'(m_tvalid4), 128'(oh4(ps4)));
            chk("dac4_tlast",  128'(m_tlast4),  128'(pl ? oh4(ps4) : 4'b0000));
            chk("dac4_tdata",  m_tdata4, {4{pd}});
            chk("src4_tready", 128'(s_tready4), 128'(1'b1));
         end
         if (i <= hi) begin
            pv = 1'b1; ps = tbl[i].esink; ps4 = tbl[i].esink4; pd = tbl[i].d; pl = tbl[i].l;
         end else begin
            pv = 1'b0;
         end
      end
   endtask

   initial begin
      // A: five 4-beat round-robin packets (0..19)
      for (int i = 0; i < 20; i++)
         add(3'd0, 32'h10 + 32'(i), (i % 4) == 3, (i / 4) % 3, (i / 4) % 4);
      // B: fixed sink 1 with a mid-packet select change, then sink 2, then rr (20..30)
      add(3'd2, 32'h40, 1'b0, 1, -1);
      for (int i = 1; i < 8; i++) add(3'd3, 32'h40 + 32'(i), i == 7, 1, -1);
      add(3'd3, 32'h50, 1'b0, 2, -1);
      add(3'd3, 32'h51, 1'b1, 2, -1);
      add(3'd0, 32'h60, 1'b1, 2, -1);
      // C: single-beat round-robin packets (31..34)
      for (int i = 0; i < 4; i++) add(3'd0, 32'h70 + 32'(i), 1'b1, i % 3, -1);
      // D1: two dropped 2-beat packets, then a fixed sink-0 packet (35..39)
      add(3'd7, 32'h80, 1'b0, 3, -1);
      add(3'd7, 32'h81, 1'b1, 3, -1);
      add(3'd7, 32'h82, 1'b0, 3, -1);
      add(3'd7, 32'h83, 1'b1, 3, -1);
      add(3'd1, 32'h90, 1'b1, 0, -1);
      // D2: two single-beat drops (40..41)
      add(3'd7, 32'h88, 1'b1, 3, -1);
      add(3'd7, 32'h89, 1'b1, 3, -1);

      rst = 1'b1; dac_sel = '0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = '0;
      repeat (2) @(negedge clk);

      // Reset state: source not ready even with valid data offered
      cyc(1'b1, 3'd0, 1'b1, 32'hDEAD, 1'b1, 3'b111, 1'b0, 3'b000, 3'b000, 32'h0);
      chk("reset_cur_route", 128'(cur_route), 128'(3'd0));
      chk("reset_drop_cnt",  128'(drop_cnt),  128'(16'd0));
      chk("reset_tvalid4",   128'(m_tvalid4), 128'(4'd0));
      chk("reset_tready4",   128'(s_tready4), 128'(1'b0));

      run_range(0, 19);
      chk("rr4_cur_route", 128'(cur_route4), 128'(3'd0));
      run_range(20, 30);
      run_range(31, 34);
      run_range(35, 39);
      chk("drop_cnt_2",    128'(drop_cnt),  128'(16'd2));
      chk("drop_cnt4_2",   128'(drop_cnt4), 128'(2'd2));
      chk("route_fixed0",  128'(cur_route), 128'(3'd0));
      run_range(40, 41);
      chk("drop_cnt_4",    128'(drop_cnt),  128'(16'd4));
      chk("drop_cnt4_sat", 128'(drop_cnt4), 128'(2'd3));
      chk("route_drop",    128'(cur_route), 128'(3'd3));

      // Backpressure on sink 0 during cycles 3-6 of a 6-beat fixed packet
      cyc(1'b0, 3'd1, 1'b1, 32'hA0, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 32'h0);
      cyc(1'b0, 3'd1, 1'b1, 32'hA1, 1'b0, 3'b111, 1'b1, 3'b001, 3'b000, 32'hA0);
      for (int c = 0; c < 4; c++)
         cyc(1'b0, 3'd1, 1'b1, 32'hA2, 1'b0, 3'b110, 1'b0, 3'b001, 3'b000, 32'hA1);
      cyc(1'b0, 3'd1, 1'b1, 32'hA2, 1'b0, 3'b111, 1'b1, 3'b001, 3'b000, 32'hA1);
      cyc(1'b0, 3'd1, 1'b1, 32'hA3, 1'b0, 3'b111, 1'b1, 3'b001, 3'b000, 32'hA2);
      cyc(1'b0, 3'd1, 1'b1, 32'hA4, 1'b0, 3'b111, 1'b1, 3'b001, 3'b000, 32'hA3);
      cyc(1'b0, 3'd1, 1'b1, 32'hA5, 1'b1, 3'b111, 1'b1, 3'b001, 3'b000, 32'hA4);
      cyc(1'b0, 3'd0, 1'b0, 32'h0,  1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 32'hA5);
      cyc(1'b0, 3'd0, 1'b0, 32'h0,  1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 32'h0);

      // Reset on beat 3 of a round-robin packet (rr_ptr is 1 here)
      cyc(1'b0, 3'd0, 1'b1, 32'hC0, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 32'h0);
      cyc(1'b0, 3'd0, 1'b1, 32'hC1, 1'b0, 3'b111, 1'b1, 3'b010, 3'b000, 32'hC0);
      cyc(1'b1, 3'd0, 1'b1, 32'hC2, 1'b0, 3'b111, 1'b0, 3'b010, 3'b000, 32'hC1);
      cyc(1'b0, 3'd0, 1'b1, 32'hD0, 1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 32'h0);
      cyc(1'b0, 3'd0, 1'b1, 32'hD1, 1'b1, 3'b111, 1'b1, 3'b001, 3'b000, 32'hD0);
      chk("post_reset_route", 128'(cur_route), 128'(3'd0));
      cyc(1'b0, 3'd0, 1'b0, 32'h0,  1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 32'hD1);
      cyc(1'b0, 3'd0, 1'b0, 32'h0,  1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/beam_mux_n.md
Name: beam_mux_n

Overview:
- Parametrised successor to the 3-DAC beam demultiplexer. Routes one AXI-Stream source to NUM_DAC DAC sinks, one whole packet at a time.
- New versus the previous generation:
  - per-sink tready backpressure;
  - tlast forwarded to the sinks;
  - registered (non-combinational) master outputs;
  - invalid-select packet drop with a saturating drop counter.
- Sits between the waveform source DMA and the DAC AXIS interfaces.

Parameters:
- DWIDTH, 32, tdata width in bits.
- NUM_DAC, 3, number of sink channels (2..16).
- SEL_W, $clog2(NUM_DAC+1), width of dac_sel.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- dac_sel  in  SEL_W  routing mode: 0 = round robin; 1..NUM_DAC = fixed sink (dac_sel-1); >NUM_DAC = drop.
- axis_S_source_tdata  in  DWIDTH  source data.
- axis_S_source_tvalid  in  1  source valid.
- axis_S_source_tready  out  1  source ready.
- axis_S_source_tlast  in  1  end of packet.
- axis_M_dac_tdata  out  NUM_DAC*DWIDTH  sink data; slice k belongs to sink k.
- axis_M_dac_tvalid  out  NUM_DAC  sink valid, one bit per sink.
- axis_M_dac_tready  in  NUM_DAC  sink ready, one bit per sink.
- axis_M_dac_tlast  out  NUM_DAC  sink last, one bit per sink.
- cur_route  out  SEL_W  route latched for the current/last packet (0..NUM_DAC-1 = sink index; NUM_DAC = drop).
- drop_cnt  out  CNT_W  number of dropped packets, saturating.

Behaviour:
- Handshakes:
  - A source beat is accepted when axis_S_source_tvalid && axis_S_source_tready.
  - A sink beat completes when axis_M_dac_tvalid[k] && axis_M_dac_tready[k].
- Packet FSM:
  - States: IDLE (next accepted beat is a packet head) and IN_PKT.
  - IDLE -> IN_PKT on an accepted beat with tlast=0.
  - IDLE stays IDLE on an accepted beat with tlast=1 (single-beat packet).
  - IN_PKT -> IDLE on an accepted beat with tlast=1.
- Route latch:
  - dac_sel is sampled only on the accepted head beat (state IDLE).
  - The route is held for the whole packet; dac_sel changes mid-packet are ignored.
  - With dac_sel=0 the route is rr_ptr.
- Round-robin pointer (rr_ptr):
  - Binary, range 0..NUM_DAC-1; reset value 0.
  - Advances by 1 (wrapping NUM_DAC-1 -> 0) on acceptance of a tlast beat, only if that packet's route came from round robin.
  - Fixed-mode and dropped packets do not move it.
- Output stage:
  - One shared register: out_v, out_data, out_last, out_tgt.
  - axis_M_dac_tvalid[k] = out_v && (out_tgt==k). All tdata slices carry out_data; all tlast bits are out_last gated by the same select.
  - axis_S_source_tready = !rst && (!out_v || axis_M_dac_tready[out_tgt]). Full throughput when the target sink is always ready.
  - On an accepted beat for a non-drop route: load the register with out_v=1. Otherwise, if the sink completes the beat, out_v=0.
  - Latency is 1 cycle, source acceptance to sink tvalid.
  - The target may change between consecutive packets with no bubble.
  - Master outputs are held stable while tvalid=1 and tready=0.
- Drop route:
  - Beats are accepted (same tready rule) and never presented to any sink.
  - drop_cnt increments once, on the accepted tlast beat, and saturates at all-ones.
- Reset values:
  - FSM=IDLE, rr_ptr=0, out_v=0, out_data=0, out_last=0, out_tgt=0.
  - cur_route=0, drop_cnt=0; all tvalid and tlast = 0; axis_S_source_tready=0.
- Reset mid-packet:
  - The in-flight packet is abandoned and the held output beat is discarded.
  - The first beat accepted after reset is treated as a packet head.

Test Plan:
- NUM_DAC=3, dac_sel=0, three 4-beat packets (data 0x10..0x1B), all sinks ready → packets appear on sinks 0, 1, 2 in order, 1-cycle latency, tlast on beats 4, 8, 12, no bubbles. Repeat with NUM_DAC=4 to check the wrap.
- dac_sel=2, switched to 3 on beat 2 of an 8-beat packet → all 8 beats go to sink 1; the next packet goes to sink 2; rr_ptr unchanged.
- dac_sel=1, axis_M_dac_tready[0] low for cycles 3-6 → source tready low those cycles, sink 0 data held stable, no beat lost or duplicated, 6-beat order intact.
- dac_sel=7 (NUM_DAC=3), two packets, then dac_sel=1 → no sink tvalid during the dropped packets; drop_cnt=2; third packet reaches sink 0. Force drop_cnt to 0xFFFF and drop one more → it stays 0xFFFF.
- Single-beat packets back-to-back, dac_sel=0 → sinks 0, 1, 2, 0 on consecutive cycles; state stays IDLE.
- rst asserted on beat 3 of 5 → all tvalid=0 next cycle and source tready=0 during reset; the next packet is routed from rr_ptr=0.
